// File: rtl/clock_pkg.sv
// Shared definitions for the pushbutton input path.
// Contents:
//   - btn_state_t / ST_* : per-channel press-tracking states (2 bits)
//   - ms_to_cyc()        : converts a millisecond duration to clk cycles
//   - DEF_*              : default timing for the 50 MHz board clock
package clock_pkg;

    typedef logic [1:0] btn_state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;  // released, waiting for a press
    localparam logic [1:0] ST_HELD   = 2'd1;  // pressed, timing towards long press
    localparam logic [1:0] ST_REPEAT = 2'd2;  // long press reached, auto-repeating

    localparam int unsigned DEF_CLK_FREQ    = 50_000_000;
    localparam int unsigned DEF_N_BTN       = 4;
    localparam int unsigned DEF_DEBOUNCE_MS = 20;
    localparam int unsigned DEF_LONG_MS     = 1000;
    localparam int unsigned DEF_REPEAT_MS   = 200;

    // Divide first so the intermediate product stays inside 32 bits for
    // realistic clock rates and durations.
    function automatic int unsigned ms_to_cyc(input int unsigned clk_freq,
                                              input int unsigned ms);
        return (clk_freq / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One pushbutton channel: 2-FF synchroniser, debounce filter, press edge,
// long-press detection and auto-repeat.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   raw          in   raw pin, active-low, asynchronous to clk
//   level        out  debounced pressed level (1 = pressed)
//   pulse        out  one-cycle pulse when a press is accepted
//   long_ev      out  one-cycle pulse when the hold reaches LONG_CYC
//   repeat_ev    out  one-cycle pulse every REP_CYC after the long press
module btn_channel
    import clock_pkg::*;
#(
    parameter int unsigned DB_CYC   = 4,
    parameter int unsigned LONG_CYC = 20,
    parameter int unsigned REP_CYC  = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic pulse,
    output logic long_ev,
    output logic repeat_ev
);

    localparam int unsigned DB_W   = $clog2(DB_CYC) + 1;
    localparam int unsigned HOLD_W = $clog2(LONG_CYC) + 1;
    localparam int unsigned REP_W  = $clog2(REP_CYC) + 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_CYC - 1);

    logic              sync1_reg, sync2_reg;
    logic              s;
    logic [DB_W-1:0]   db_cnt_reg, db_cnt_next;
    logic              level_reg, level_next;
    logic              rise, fall;
    btn_state_t        state_reg, state_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic [REP_W-1:0]  rep_reg, rep_next;
    logic              pulse_reg, pulse_next;
    logic              long_reg, long_next;
    logic              repeat_reg, repeat_next;

    assign s = ~sync2_reg;

    // Debounce: count consecutive cycles of disagreement; the count never
    // passes DB_LAST because reaching it toggles the level and clears.
    always_comb begin
        db_cnt_next = db_cnt_reg;
        level_next  = level_reg;
        if (s == level_reg) begin
            db_cnt_next = '0;
        end else if (db_cnt_reg == DB_LAST) begin
            level_next  = ~level_reg;
            db_cnt_next = '0;
        end else begin
            db_cnt_next = db_cnt_reg + DB_W'(1);
        end
    end

    // Edges are taken from the next level so the pulse lands on the same
    // edge as the level change.
    assign rise = level_next & ~level_reg;
    assign fall = ~level_next & level_reg;

    // Release is tested before terminal counts so a falling level always
    // suppresses long/repeat on that edge.
    always_comb begin
        state_next  = state_reg;
        hold_next   = hold_reg;
        rep_next    = rep_reg;
        pulse_next  = 1'b0;
        long_next   = 1'b0;
        repeat_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rise) begin
                    pulse_next = 1'b1;
                    hold_next  = '0;
                    state_next = ST_HELD;
                end
            end
            ST_HELD: begin
                if (fall) begin
                    state_next = ST_IDLE;
                end else if (hold_reg == LONG_LAST) begin
                    long_next  = 1'b1;
                    rep_next   = '0;
                    state_next = ST_REPEAT;
                end else begin
                    hold_next = hold_reg + HOLD_W'(1);
                end
            end
            ST_REPEAT: begin
                if (fall) begin
                    state_next = ST_IDLE;
                end else if (rep_reg == REP_LAST) begin
                    repeat_next = 1'b1;
                    rep_next    = '0;
                end else begin
                    rep_next = rep_reg + REP_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg  <= 1'b1;
            sync2_reg  <= 1'b1;
            db_cnt_reg <= '0;
            level_reg  <= 1'b0;
            state_reg  <= ST_IDLE;
            hold_reg   <= '0;
            rep_reg    <= '0;
            pulse_reg  <= 1'b0;
            long_reg   <= 1'b0;
            repeat_reg <= 1'b0;
        end else begin
            sync1_reg  <= raw;
            sync2_reg  <= sync1_reg;
            db_cnt_reg <= db_cnt_next;
            level_reg  <= level_next;
            state_reg  <= state_next;
            hold_reg   <= hold_next;
            rep_reg    <= rep_next;
            pulse_reg  <= pulse_next;
            long_reg   <= long_next;
            repeat_reg <= repeat_next;
        end
    end

    assign level     = level_reg;
    assign pulse     = pulse_reg;
    assign long_ev   = long_reg;
    assign repeat_ev = repeat_reg;

endmodule

// File: rtl/btn_conditioner.sv
// Turns raw bouncing pushbuttons into clean level and event pulses.
// Bit 3 is the mode button, bits 2:0 are the setting buttons.
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-low reset
//   btn_raw     in   raw pins, active-low, asynchronous to clk
//   btn_level   out  debounced pressed level (1 = pressed)
//   btn_pulse   out  one-cycle pulse on accepted press
//   btn_long    out  one-cycle pulse once per hold at LONG_MS
//   btn_repeat  out  one-cycle pulse every REPEAT_MS after the long press
module btn_conditioner
    import clock_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = DEF_CLK_FREQ,
    parameter int unsigned N_BTN       = DEF_N_BTN,
    parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS,
    parameter int unsigned LONG_MS     = DEF_LONG_MS,
    parameter int unsigned REPEAT_MS   = DEF_REPEAT_MS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_long,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int unsigned DB_CYC   = ms_to_cyc(CLK_FREQ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYC = ms_to_cyc(CLK_FREQ, LONG_MS);
    localparam int unsigned REP_CYC  = ms_to_cyc(CLK_FREQ, REPEAT_MS);

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
            btn_channel #(
                .DB_CYC   (DB_CYC),
                .LONG_CYC (LONG_CYC),
                .REP_CYC  (REP_CYC)
            ) u_ch (
                .clk       (clk),
                .reset     (reset),
                .raw       (btn_raw[gi]),
                .level     (btn_level[gi]),
                .pulse     (btn_pulse[gi]),
                .long_ev   (btn_long[gi]),
                .repeat_ev (btn_repeat[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

    localparam int N  = 4;
    localparam int DB = 4;
    localparam int LG = 20;
    localparam int RP = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btn_raw = 4'hF;
    logic [3:0] btn_level, btn_pulse, btn_long, btn_repeat;

    always #5 clk = ~clk;

    btn_conditioner #(
        .CLK_FREQ    (1000),
        .N_BTN       (4),
        .DEBOUNCE_MS (4),
        .LONG_MS     (20),
        .REPEAT_MS   (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_pulse  (btn_pulse),
        .btn_long   (btn_long),
        .btn_repeat (btn_repeat)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- behavioural model ----------------
    // Level flips once the synchronised input has disagreed with it for the
    // last DB samples; events are timed from the press cycle by arithmetic.
    int         cyc = 0;
    logic [3:0] m_sync1 = 4'hF;
    logic [3:0] m_sync2 = 4'hF;
    logic [3:0] m_level = 4'h0;
    logic [3:0] m_pulse = 4'h0;
    logic [3:0] m_long  = 4'h0;
    logic [3:0] m_rep   = 4'h0;
    int         win[4][$];
    int         press_t[4];
    int         s_v, el, ndiff;
    bit         tog, rise_v, fall_v;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int b = 0; b < N; b++) begin
                if (!reset) begin
                    m_sync1[b] = 1'b1;
                    m_sync2[b] = 1'b1;
                    m_level[b] = 1'b0;
                    m_pulse[b] = 1'b0;
                    m_long[b]  = 1'b0;
                    m_rep[b]   = 1'b0;
                    win[b].delete();
                end else begin
                    s_v = m_sync2[b] ? 0 : 1;
                    win[b].push_back(s_v);
                    if (win[b].size() > DB) void'(win[b].pop_front());
                    ndiff = 0;
                    for (int i = 0; i < win[b].size(); i++)
                        if (win[b][i] != int'(m_level[b])) ndiff++;
                    tog    = (ndiff == DB);
                    rise_v = tog && !m_level[b];
                    fall_v = tog && m_level[b];
                    m_pulse[b] = 1'b0;
                    m_long[b]  = 1'b0;
                    m_rep[b]   = 1'b0;
                    if (rise_v) begin
                        m_pulse[b] = 1'b1;
                        press_t[b] = cyc;
                    end else if (m_level[b] && !fall_v) begin
                        el = cyc - press_t[b];
                        if (el == LG) m_long[b] = 1'b1;
                        else if (el > LG && ((el - LG) % RP) == 0) m_rep[b] = 1'b1;
                    end
                    m_level[b] = m_level[b] ^ tog;
                    m_sync2[b] = m_sync1[b];
                    m_sync1[b] = btn_raw[b];
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [15:0] exp_v, act_v;
    int          pulse_cnt1 = 0;

    initial begin
        forever begin
            @(negedge clk);
            exp_v = reset ? {m_level, m_pulse, m_long, m_rep} : 16'h0;
            act_v = {btn_level, btn_pulse, btn_long, btn_repeat};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL model_cycle%0d: level/pulse/long/repeat got %b/%b/%b/%b expected %b/%b/%b/%b",
                         cyc, act_v[15:12], act_v[11:8], act_v[7:4], act_v[3:0],
                         exp_v[15:12], exp_v[11:8], exp_v[7:4], exp_v[3:0]);
            end
            if (btn_pulse[1] === 1'b1) pulse_cnt1++;
        end
    end

    // ---------------- directed stimulus ----------------
    int rel;
    int snap;
    logic [3:0] acc;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            rel++;
        end
    endtask

    task automatic goto_rel(input int k);
        while (rel < k) step(1);
    endtask

    task automatic start();
        @(posedge clk);
        #2;
        rel = 0;
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("check %s: %0h ok", nm, act);
        end
    endtask

    initial begin
        rel = 0;
        repeat (3) @(posedge clk);
        #2;
        lit("reset_level", 32'(btn_level), 32'h0);
        lit("reset_events", 32'({btn_pulse, btn_long, btn_repeat}), 32'h0);
        reset = 1'b1;
        step(10);

        // Clean press on bit 0
        start();
        btn_raw[0] = 1'b0;
        goto_rel(5);  lit("clean_pulse_c5", 32'(btn_pulse), 32'h0);
                      lit("clean_level_c5", 32'(btn_level), 32'h0);
        goto_rel(6);  lit("clean_pulse_c6", 32'(btn_pulse), 32'h1);
                      lit("clean_level_c6", 32'(btn_level), 32'h1);
        goto_rel(7);  lit("clean_pulse_c7", 32'(btn_pulse), 32'h0);
        goto_rel(10); btn_raw[0] = 1'b1;
        goto_rel(15); lit("clean_level_c15", 32'(btn_level), 32'h1);
        goto_rel(16); lit("clean_level_c16", 32'(btn_level), 32'h0);
        step(20);

        // Bouncing press on bit 1
        snap = pulse_cnt1;
        start();
        for (int i = 0; i < 6; i++) begin
            goto_rel(2 * i);
            btn_raw[1] = i[0];
        end
        goto_rel(12); btn_raw[1] = 1'b0;
        goto_rel(17); lit("bounce_pulse_c17", 32'(btn_pulse), 32'h0);
        goto_rel(18); lit("bounce_pulse_c18", 32'(btn_pulse), 32'h2);
        goto_rel(30); lit("bounce_pulse_count", 32'(pulse_cnt1 - snap), 32'd1);
        btn_raw[1] = 1'b1;
        step(20);

        // 3-cycle glitch on bit 1
        start();
        acc = 4'h0;
        btn_raw[1] = 1'b0;
        goto_rel(3); btn_raw[1] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            goto_rel(k);
            acc = acc | btn_level | btn_pulse | btn_long | btn_repeat;
        end
        lit("glitch_no_output", 32'(acc), 32'h0);
        step(10);

        // Long hold on bit 2
        start();
        btn_raw[2] = 1'b0;
        goto_rel(6);  lit("long_pulse_c6", 32'(btn_pulse), 32'h4);
        goto_rel(25); lit("long_long_c25", 32'(btn_long), 32'h0);
        goto_rel(26); lit("long_long_c26", 32'(btn_long), 32'h4);
                      lit("long_pulse_c26", 32'(btn_pulse), 32'h0);
        goto_rel(30); lit("long_rep_c30", 32'(btn_repeat), 32'h0);
        goto_rel(31); lit("long_rep_c31", 32'(btn_repeat), 32'h4);
        goto_rel(36); lit("long_rep_c36", 32'(btn_repeat), 32'h4);
        goto_rel(40); btn_raw[2] = 1'b1;
        goto_rel(41); lit("long_rep_c41", 32'(btn_repeat), 32'h4);
        goto_rel(45); lit("long_level_c45", 32'(btn_level), 32'h4);
        goto_rel(46); lit("long_level_c46", 32'(btn_level), 32'h0);
                      lit("long_rep_c46_release_wins", 32'(btn_repeat), 32'h0);
        step(20);

        // Reset while bit 0 is held
        start();
        btn_raw[0] = 1'b0;
        goto_rel(6);  lit("rst_pulse_c6", 32'(btn_pulse), 32'h1);
        goto_rel(15); reset = 1'b0;
        #1;           lit("rst_level_c15", 32'(btn_level), 32'h0);
        goto_rel(18); reset = 1'b1;
        goto_rel(23); lit("rst_pulse_c23", 32'(btn_pulse), 32'h0);
        goto_rel(24); lit("rst_pulse_c24", 32'(btn_pulse), 32'h1);
        goto_rel(43); lit("rst_long_c43", 32'(btn_long), 32'h0);
        goto_rel(44); lit("rst_long_c44", 32'(btn_long), 32'h1);
        btn_raw[0] = 1'b1;
        step(20);

        // Simultaneous press on bits 3 and 0
        start();
        btn_raw = 4'b0110;
        goto_rel(5);  lit("sim_pulse_c5", 32'(btn_pulse), 32'h0);
        goto_rel(6);  lit("sim_pulse_c6", 32'(btn_pulse), 32'h9);
        goto_rel(8);  btn_raw[0] = 1'b1;
        goto_rel(14); lit("sim_level_c14", 32'(btn_level), 32'h8);
        goto_rel(26); lit("sim_long_c26", 32'(btn_long), 32'h8);
        goto_rel(30); btn_raw[3] = 1'b1;
        goto_rel(36); lit("sim_level_c36", 32'(btn_level), 32'h0);
        step(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Input-side counterpart of the display path. It turns raw, bouncing board pushbuttons (btn_3 plus btn[2:0]) into clean single-cycle event pulses for the mode fsm and the button demux.
- Per button: 2-FF synchroniser, debounce filter, press edge detect, long-press detect and auto-repeat while held. Auto-repeat drives fast increment in clock/alarm/temp setting.
- Sits between the board pins and fsm/demux inside top_reloj; runs on the 50 MHz clk only, no derived clocks.

Parameters:
- CLK_FREQ, 50_000_000, clk frequency in Hz.
- N_BTN, 4, number of buttons; bit 3 = mode button, bits 2:0 = btn[2:0].
- DEBOUNCE_MS, 20, stability window; DB_CYC = CLK_FREQ/1000*DEBOUNCE_MS, must be ≥1.
- LONG_MS, 1000, hold time before long press; LONG_CYC = CLK_FREQ/1000*LONG_MS.
- REPEAT_MS, 200, auto-repeat period after long press; REP_CYC = CLK_FREQ/1000*REPEAT_MS.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous, active-low reset.
- btn_raw, in, N_BTN, raw button pins, active-low (0 = pressed), asynchronous to clk.
- btn_level, out, N_BTN, debounced pressed level (1 = pressed).
- btn_pulse, out, N_BTN, one-cycle pulse on accepted press.
- btn_long, out, N_BTN, one-cycle pulse once per hold when the hold reaches LONG_CYC.
- btn_repeat, out, N_BTN, one-cycle pulse every REP_CYC while held after the long press.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-low.
- Reset values: sync FFs = 1 (released); btn_level, btn_pulse, btn_long, btn_repeat = 0; all counters = 0; all channels in IDLE.
- Channels are fully independent; simultaneous events on different bits are all reported in the same cycle.
- Synchroniser: 2 FFs. s = ~sync2 (pressed = 1).
- Debounce:
  - The counter increments each cycle s ≠ btn_level and clears on any cycle s == btn_level.
  - When the count reaches DB_CYC−1 while still differing, btn_level toggles at the next edge and the counter clears.
  - Latency from a stable raw change to the btn_level change is exactly 2 + DB_CYC cycles.
  - Any glitch shorter than DB_CYC synchronised cycles produces no output.
- Per-channel FSM states:
  - IDLE: btn_level rises → btn_pulse = 1 for that one edge; hold counter = 0; go to HELD.
  - HELD: hold counter increments each cycle. Count == LONG_CYC−1 → btn_long pulse; repeat counter = 0; go to REPEAT. btn_level falls → IDLE, no long.
  - REPEAT: repeat counter increments. Count == REP_CYC−1 → btn_repeat pulse and counter cleared. btn_level falls → IDLE.
- Boundary rules:
  - Release wins: on the cycle btn_level falls, no btn_long or btn_repeat is issued even if a counter hits terminal count.
  - btn_pulse, btn_long and btn_repeat are never asserted in the same cycle on the same bit.
  - Counters saturate or clear as stated and never wrap.
- Reset mid-press: outputs go to 0 immediately (async). After reset deasserts with the button still held, the press is re-accepted as new, with btn_pulse 2 + DB_CYC cycles after reset release.
- Widths: each counter is $clog2 of its terminal value, +1 bit. Comparisons are unsigned.
- All outputs are registered, with no combinational path from btn_raw.

Decomposition:
- Shared package clock_pkg holds:
  - the state enum (IDLE, HELD, REPEAT, 2 bits);
  - a ms-to-cycles constant function;
  - the default timing constants.
- Sub-module btn_channel implements the synchroniser, debounce and FSM for 1 bit. btn_conditioner is a generate loop over N_BTN instances.

Test Plan:
- Bench parameters: CLK_FREQ=1000, DEBOUNCE_MS=4, LONG_MS=20, REPEAT_MS=5, giving DB_CYC=4, LONG_CYC=20, REP_CYC=5. Cycle numbers below count from the first raw edge.
- Clean press: btn_raw[0] low at cycle 0 for 10 cycles → btn_pulse[0] at cycle 6 only; btn_level[0] high from 6 until 16; no long or repeat.
- Bounce: btn_raw[1] toggles every 2 cycles for 12 cycles, then stays low → exactly one btn_pulse[1], 6 cycles after the last toggle. A separate 3-cycle low glitch → no output at all.
- Long hold: btn_raw[2] low from 0 to 40 → pulse at 6, btn_long at 26, btn_repeat at 31, 36 and 41. btn_level falls at 46, where the repeat is suppressed because release wins.
- Reset mid-hold: btn_raw[0] held low; reset low during cycles 15–18 → all outputs 0 from 15; pulse at 24, long at 44.
- Simultaneous: btn_raw[3] and btn_raw[0] low in the same cycle → btn_pulse = 4'b1001 in a single cycle (cycle 6), then both channels track independently.
